// File: rtl/jpeg_frame_sequencer.sv
// jpeg_frame_sequencer: admits one frame at a time, requests the JPEG header, forwards pixels with regenerated sideband and waits for the encoder to drain
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   s_axis_*                        RGB pixel input stream (tlast/tuser only checked)
//   m_axis_*                        pixel output to the colour-space converter
//   hdr_req / hdr_ack               header request handshake with the file generator
//   enc_done                        final encoded byte handshake from the encoder
//   err_clr                         clears the sticky error flags
//   frame_busy, frame_count         frame status
//   err_sof, err_eol, err_timeout   sticky framing / drain errors
module jpeg_frame_sequencer #(
   parameter int IMG_WIDTH     = 256,
   parameter int IMG_HEIGHT    = 256,
   parameter int DATA_WIDTH    = 24,
   parameter int DRAIN_TIMEOUT = 65535
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  hdr_req,
   input  logic                  hdr_ack,
   input  logic                  enc_done,
   input  logic                  err_clr,
   output logic                  frame_busy,
   output logic [15:0]           frame_count,
   output logic                  err_sof,
   output logic                  err_eol,
   output logic                  err_timeout
);
   localparam int XW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
   localparam int YW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, HEADER, ACTIVE, DRAIN} state_t;
   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [TW-1:0]   t_q, t_d;
   logic [15:0]     fc_q, fc_d;
   logic            hdr_q, sof_q, eol_q, to_q;
   logic            set_sof, set_eol, set_to;
   logic            first_px, last_x, last_y, xfer;
   assign first_px    = (x_q == '0) && (y_q == '0);
   assign last_x      = x_q == XW'(IMG_WIDTH - 1);
   assign last_y      = y_q == YW'(IMG_HEIGHT - 1);
   assign xfer        = s_axis_tvalid && m_axis_tready;
   assign frame_busy  = state_q != IDLE;
   assign frame_count = fc_q;
   assign hdr_req     = hdr_q;
   assign err_sof     = sof_q;
   assign err_eol     = eol_q;
   assign err_timeout = to_q;
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      t_d           = t_q;
      fc_d          = fc_q;
      set_sof       = 1'b0;
      set_eol       = 1'b0;
      set_to        = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tuser  = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = s_axis_tdata;
      case (state_q)
         IDLE: begin
            // the SOF beat is held back until the header has been accepted
            s_axis_tready = rst_n && !s_axis_tuser;
            set_sof       = s_axis_tvalid && !s_axis_tuser;
            state_d       = (s_axis_tvalid && s_axis_tuser) ? HEADER : IDLE;
         end
         HEADER: state_d = hdr_ack ? ACTIVE : HEADER;
         ACTIVE: begin
            s_axis_tready = rst_n && m_axis_tready;
            m_axis_tvalid = rst_n && s_axis_tvalid;
            m_axis_tuser  = rst_n && first_px;
            m_axis_tlast  = rst_n && last_x;
            if (xfer) begin
               set_eol = last_x != s_axis_tlast;
               set_sof = s_axis_tuser && !first_px;
               x_d     = last_x ? '0 : x_q + 1'b1;
               y_d     = last_x ? (last_y ? '0 : y_q + 1'b1) : y_q;
               state_d = (last_x && last_y) ? DRAIN : ACTIVE;
            end
         end
         DRAIN: begin
            // enc_done takes priority over a coincident timeout
            set_to  = !enc_done && (t_q == TW'(DRAIN_TIMEOUT - 1));
            fc_d    = enc_done ? fc_q + 16'd1 : fc_q;
            t_d     = (enc_done || set_to) ? '0 : t_q + 1'b1;
            state_d = (enc_done || set_to) ? IDLE : DRAIN;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         t_q     <= '0;
         fc_q    <= '0;
         hdr_q   <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         t_q     <= t_d;
         fc_q    <= fc_d;
         hdr_q   <= state_d == HEADER;
         sof_q   <= set_sof || (sof_q && !err_clr);
         eol_q   <= set_eol || (eol_q && !err_clr);
         to_q    <= set_to || (to_q && !err_clr);
      end
   end
endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
// tb_jpeg_frame_sequencer: randomized frame stimulus checked against a pixel-index reference model
module tb_jpeg_frame_sequencer;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int N  = W * H;
   localparam int TO = 10;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] s_axis_tdata, m_axis_tdata;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
   logic        hdr_req, hdr_ack, enc_done, err_clr, frame_busy;
   logic [15:0] frame_count;
   logic        err_sof, err_eol, err_timeout;
   int          checks = 0, fails = 0;
   int          mode = 0, ack_dly = 3, hlen = 0, hk = 0;
   int          exp_fc = 0;
   bit          exp_sof = 0, exp_eol = 0, exp_to = 0;
   logic [25:0] got[$];
   jpeg_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(24), .DRAIN_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .hdr_req(hdr_req), .hdr_ack(hdr_ack), .enc_done(enc_done), .err_clr(err_clr),
      .frame_busy(frame_busy), .frame_count(frame_count),
      .err_sof(err_sof), .err_eol(err_eol), .err_timeout(err_timeout)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~m_axis_tready : 1'($urandom_range(0, 1));
      end
   end
   initial begin
      hdr_ack = 1'b0;
      forever begin
         bit nxt;
         @(negedge clk);
         if (hdr_req) hk++;
         else begin
            if (hk != 0) hlen = hk;
            hk = 0;
         end
         nxt = hdr_req && (hk == ack_dly - 1);
         @(posedge clk);
         #1;
         hdr_ack = nxt;
      end
   end
   always @(negedge clk) begin
      if (rst_n && m_axis_tvalid) begin
         chk("rdy_mirror", 32'(s_axis_tready), 32'(m_axis_tready));
         if (m_axis_tready) got.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      end
   end
   task automatic put(input logic [23:0] d, input logic u, input logic l);
      int n = 0;
      bit ok = 0;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!ok) begin
         @(negedge clk);
         ok = s_axis_tready;
         n++;
         if (!ok && n > 200) begin
            chk("accept_timeout", 0, 1);
            ok = 1;
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask
   task automatic status();
      chk("busy", 32'(frame_busy), 0);
      chk("frame_count", 32'(frame_count), 32'(exp_fc));
      chk("err_sof", 32'(err_sof), 32'(exp_sof));
      chk("err_eol", 32'(err_eol), 32'(exp_eol));
      chk("err_timeout", 32'(err_timeout), 32'(exp_to));
   endtask
   task automatic run_frame(input int strays, input logic [7:0] eol_m, input logic [7:0] sof_m,
                            input bit done, input int md, input int ad);
      logic [23:0] pix[N];
      mode    = md;
      ack_dly = ad;
      hlen    = 0;
      got.delete();
      for (int i = 0; i < strays; i++) put(24'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < N; k++) begin
         if (md == 2 && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         pix[k] = 24'($urandom);
         put(pix[k], (k == 0) || sof_m[k], ((k % W) == W - 1) ^ eol_m[k]);
      end
      exp_sof = exp_sof || strays > 0 || |(sof_m & 8'hFE);
      exp_eol = exp_eol || |eol_m;
      chk("hdr_len", hlen, ad);
      chk("beats", got.size(), N);
      for (int k = 0; k < N && k < got.size(); k++)
         chk("beat", 32'(got[k]), 32'({pix[k], k == 0, (k % W) == W - 1}));
      if (done) begin
         repeat ($urandom_range(0, 4)) begin
            @(posedge clk);
            #1;
         end
         enc_done = 1'b1;
         @(posedge clk);
         #1;
         enc_done = 1'b0;
         exp_fc++;
      end else begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!err_timeout && n < 40);
         chk("timeout_cycles", n - 1, TO);
         exp_to = 1;
      end
      @(negedge clk);
      status();
      if (exp_sof || exp_eol || exp_to) begin
         @(posedge clk);
         #1;
         err_clr = 1'b1;
         @(posedge clk);
         #1;
         err_clr = 1'b0;
         exp_sof = 0;
         exp_eol = 0;
         exp_to  = 0;
         @(negedge clk);
         status();
      end
   endtask
   initial begin
      rst_n = 1'b0;
      s_axis_tdata = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      s_axis_tuser = 1'b0;
      enc_done = 1'b0;
      err_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_tready", 32'(s_axis_tready), 0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_hdr_req", 32'(hdr_req), 0);
      chk("rst_m_tuser", 32'(m_axis_tuser), 0);
      chk("rst_m_tlast", 32'(m_axis_tlast), 0);
      status();
      run_frame(0, 8'h00, 8'h00, 1, 0, 3);
      run_frame(0, 8'h00, 8'h00, 1, 1, 3);
      run_frame(3, 8'h00, 8'h00, 1, 0, 2);
      run_frame(0, 8'h0C, 8'h00, 1, 0, 4);
      for (int i = 0; i < 6; i++)
         run_frame($urandom_range(0, 1) * $urandom_range(1, 3),
                   ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
                   ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(1, 7)) : 8'h00,
                   1, $urandom_range(0, 2), $urandom_range(2, 5));
      run_frame(0, 8'h00, 8'h00, 0, 0, 3);
      run_frame(0, 8'h00, 8'h00, 1, 2, 2);
      mode = 0;
      ack_dly = 2;
      put(24'h123456, 1'b1, 1'b0);
      for (int k = 1; k < 5; k++) put(24'($urandom), 1'b0, (k % W) == W - 1);
      s_axis_tvalid = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_s_tready", 32'(s_axis_tready), 0);
      chk("midrst_m_tvalid", 32'(m_axis_tvalid), 0);
      chk("midrst_m_tuser", 32'(m_axis_tuser), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_axis_tvalid = 1'b0;
      exp_fc = 0;
      @(negedge clk);
      chk("midrst_hdr_req", 32'(hdr_req), 0);
      status();
      run_frame(0, 8'h00, 8'h00, 1, 0, 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
